// File: rtl/watchdog_pkg.sv
// Shared types for the multi-channel watchdog.
//
// Contents:
//   wd_state_e  per-channel watchdog state, used by wd_channel.
package watchdog_pkg;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_RUN     = 2'd1,
    WD_WARN    = 2'd2,
    WD_EXPIRED = 2'd3
  } wd_state_e;

endpackage

// File: rtl/wd_channel.sv
// One watchdog channel: state machine plus a saturating up-counter.
// The counter advances on the shared prescaler tick. When the count reaches
// the latched timeout, the channel expires and stays expired until
// clear_status.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   en              channel enable (level)
//   kick            service pulse: restart the count and re-latch limits
//   clear_status    leaves EXPIRED
//   tick            one-cycle prescaler pulse from the top level
//   timeout         timeout value, latched at IDLE exit and on kick
//   warn_thresh     warning count, latched with timeout; 0 disables warning
//   count           current count (registered)
//   warn            channel is in WARN (registered)
//   expired         channel is in EXPIRED (registered, sticky)
//
// state      | meaning
// WD_IDLE    | disabled, count held at 0
// WD_RUN     | counting, below warning threshold
// WD_WARN    | counting, warning threshold reached
// WD_EXPIRED | timed out; kick/en ignored until clear_status
module wd_channel
  import watchdog_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             kick,
  input  logic             clear_status,
  input  logic             tick,
  input  logic [WIDTH-1:0] timeout,
  input  logic [WIDTH-1:0] warn_thresh,
  output logic [WIDTH-1:0] count,
  output logic             warn,
  output logic             expired
);

  wd_state_e        state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] to_l, to_nxt;
  logic [WIDTH-1:0] wt_l, wt_nxt;
  logic [WIDTH-1:0] count_inc;

  assign count_inc = count + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= WD_IDLE;
      count   <= '0;
      to_l    <= '0;
      wt_l    <= '0;
      warn    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      to_l    <= to_nxt;
      wt_l    <= wt_nxt;
      warn    <= (state_nxt == WD_WARN);
      expired <= (state_nxt == WD_EXPIRED);
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    to_nxt    = to_l;
    wt_nxt    = wt_l;
    case (state)
      WD_IDLE: begin
        count_nxt = '0;
        if (en) begin
          state_nxt = WD_RUN;
          to_nxt    = timeout;
          wt_nxt    = warn_thresh;
        end
      end
      WD_RUN, WD_WARN: begin
        if (!en) begin
          state_nxt = WD_IDLE;
          count_nxt = '0;
        end else if (kick) begin
          state_nxt = WD_RUN;
          count_nxt = '0;
          to_nxt    = timeout;
          wt_nxt    = warn_thresh;
        end else if (tick) begin
          // Expiry is checked before incrementing, so the count never wraps
          // and freezes at the timeout value.
          if (count == to_l) begin
            state_nxt = WD_EXPIRED;
          end else begin
            count_nxt = count_inc;
            if (state == WD_RUN && wt_l != '0 && count_inc == wt_l)
              state_nxt = WD_WARN;
          end
        end
      end
      WD_EXPIRED: begin
        if (clear_status) begin
          state_nxt = WD_IDLE;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = WD_IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/multi_watchdog.sv
// Multi-channel watchdog: N_CH independent wd_channel instances sharing one
// programmable tick prescaler, plus a registered halt request that is the OR
// of all expired flags.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   prescale_div   tick period minus one (0 = tick every cycle)
//   en             per-channel enable
//   kick           per-channel service pulse
//   timeout        per-channel timeout, channel i at [i*WIDTH +: WIDTH]
//   warn_thresh    per-channel warning count, 0 disables warning
//   clear_status   per-channel pulse that leaves EXPIRED
//   count          per-channel current count
//   warn           per-channel WARN flag
//   expired        per-channel sticky EXPIRED flag
//   halt_req       registered OR of expired
module multi_watchdog
  import watchdog_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [PRESCALE_W-1:0]   prescale_div,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         kick,
  input  logic [N_CH*WIDTH-1:0]   timeout,
  input  logic [N_CH*WIDTH-1:0]   warn_thresh,
  input  logic [N_CH-1:0]         clear_status,
  output logic [N_CH*WIDTH-1:0]   count,
  output logic [N_CH-1:0]         warn,
  output logic [N_CH-1:0]         expired,
  output logic                    halt_req
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  any_en;
  logic                  tick;

  assign any_en = |en;
  // ">=" rather than "==" so lowering prescale_div mid-count ticks at once
  // instead of waiting for the counter to wrap.
  assign tick   = any_en && (pre_cnt >= prescale_div);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt <= '0;
    end else if (!any_en || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_req <= 1'b0;
    end else begin
      halt_req <= |expired;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wd_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk          (clk),
      .rstn         (rstn),
      .en           (en[i]),
      .kick         (kick[i]),
      .clear_status (clear_status[i]),
      .tick         (tick),
      .timeout      (timeout[i*WIDTH +: WIDTH]),
      .warn_thresh  (warn_thresh[i*WIDTH +: WIDTH]),
      .count        (count[i*WIDTH +: WIDTH]),
      .warn         (warn[i]),
      .expired      (expired[i])
    );
  end

endmodule
